// File: rtl/bypass_buff_mp_pkg.sv
// Shared types and default sizing for the register-read write-back bypass buffer.
package bypass_buff_mp_pkg;

   localparam int unsigned BYPASS_BUFF_SIZE  = 8;
   localparam int unsigned BYPASS_NUM_SRC    = 3;
   localparam int unsigned BYPASS_WIDTH_IDX  = 8;
   localparam int unsigned BYPASS_WIDTH_DATA = 32;

   typedef logic [BYPASS_WIDTH_IDX-1:0]  bypass_idx_t;
   typedef logic [BYPASS_WIDTH_DATA-1:0] bypass_data_t;

endpackage

// File: rtl/bypass_buff_mp_age_sel.sv
// Picks the lowest free entry and the oldest valid entry (lowest number on an age tie).
module bypass_buff_mp_age_sel
   import bypass_buff_mp_pkg::*;
#(
   parameter int unsigned BUFF_SIZE = BYPASS_BUFF_SIZE,
   parameter int unsigned WIDTH_NUM = $clog2(BYPASS_BUFF_SIZE) + 1
) (
   input  logic [BUFF_SIZE-1:0]           valid,
   input  logic [BUFF_SIZE*WIDTH_NUM-1:0] age,
   output logic [$clog2(BUFF_SIZE)-1:0]   free_ptr,
   output logic [$clog2(BUFF_SIZE)-1:0]   victim_ptr,
   output logic                           any_free
);

   localparam int unsigned WIDTH_PTR = $clog2(BUFF_SIZE);

   logic [WIDTH_NUM-1:0] best_age;
   logic                 found;

   always_comb begin
      free_ptr   = '0;
      victim_ptr = '0;
      any_free   = 1'b0;
      best_age   = '0;
      found      = 1'b0;
      for (int unsigned e = 0; e < BUFF_SIZE; e++) begin
         if (!valid[e] && !any_free) begin
            free_ptr = WIDTH_PTR'(e);
            any_free = 1'b1;
         end
         // strict compare keeps the lowest-numbered entry on a tie
         if (valid[e] && (!found || age[e*WIDTH_NUM +: WIDTH_NUM] > best_age)) begin
            victim_ptr = WIDTH_PTR'(e);
            best_age   = age[e*WIDTH_NUM +: WIDTH_NUM];
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bypass_buff_mp.sv
// Multi-port write-back bypass buffer: tags recent write-backs by register index and
// overrides stale register-file operands on a match.
module bypass_buff_mp
   import bypass_buff_mp_pkg::*;
#(
   parameter int unsigned BUFF_SIZE  = BYPASS_BUFF_SIZE,
   parameter int unsigned NUM_SRC    = BYPASS_NUM_SRC,
   parameter int unsigned WIDTH_IDX  = BYPASS_WIDTH_IDX,
   parameter int unsigned WIDTH_DATA = BYPASS_WIDTH_DATA,
   parameter int unsigned FWD_WB     = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          I_Stall,
   input  logic                          I_Flush,
   input  logic                          I_WB_Valid,
   input  logic [WIDTH_IDX-1:0]          I_WB_Idx,
   input  logic [WIDTH_DATA-1:0]         I_WB_Data,
   input  logic [NUM_SRC-1:0]            I_Src_Valid,
   input  logic [NUM_SRC*WIDTH_IDX-1:0]  I_Src_Idx,
   input  logic [NUM_SRC-1:0]            I_Src_Last,
   input  logic [NUM_SRC*WIDTH_DATA-1:0] I_Src_Data,
   output logic [NUM_SRC*WIDTH_DATA-1:0] O_Src_Data,
   output logic [NUM_SRC-1:0]            O_Src_Hit,
   output logic                          O_Evict,
   output logic [$clog2(BUFF_SIZE):0]    O_Num,
   output logic                          O_Full,
   output logic                          O_Empty
);

   localparam int unsigned WIDTH_NUM = $clog2(BUFF_SIZE) + 1;
   localparam int unsigned WIDTH_PTR = $clog2(BUFF_SIZE);

   logic [BUFF_SIZE-1:0]  valid_q, valid_d, valid_kept, rel_mask;
   logic [WIDTH_IDX-1:0]  idx_q  [BUFF_SIZE];
   logic [WIDTH_IDX-1:0]  idx_d  [BUFF_SIZE];
   logic [WIDTH_DATA-1:0] data_q [BUFF_SIZE];
   logic [WIDTH_DATA-1:0] data_d [BUFF_SIZE];
   logic [WIDTH_NUM-1:0]  age_q  [BUFF_SIZE];
   logic [WIDTH_NUM-1:0]  age_d  [BUFF_SIZE];
   logic [BUFF_SIZE*WIDTH_NUM-1:0] age_flat;

   logic [WIDTH_IDX-1:0]  src_idx  [NUM_SRC];
   logic [WIDTH_DATA-1:0] buf_data [NUM_SRC];
   logic [NUM_SRC-1:0]    fwd_hit, buf_hit;

   logic                 wb_present, any_free, evict_d;
   logic [WIDTH_PTR-1:0] wb_ptr, free_ptr, victim_ptr, tgt_ptr;
   logic [WIDTH_NUM-1:0] num_d;

   always_comb begin
      O_Src_Data = '0;
      O_Src_Hit  = '0;
      rel_mask   = '0;
      fwd_hit    = '0;
      buf_hit    = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         src_idx[k]  = I_Src_Idx[k*WIDTH_IDX +: WIDTH_IDX];
         buf_data[k] = '0;
         fwd_hit[k]  = (FWD_WB != 0) && I_WB_Valid && I_Src_Valid[k] && (src_idx[k] == I_WB_Idx);
         for (int unsigned e = 0; e < BUFF_SIZE; e++) begin
            if (valid_q[e] && (idx_q[e] == src_idx[k])) begin
               buf_hit[k]  = I_Src_Valid[k];
               buf_data[k] = data_q[e];
               // only a genuine buffer hit (not a forwarded one) releases the entry
               if (I_Src_Valid[k] && I_Src_Last[k] && !fwd_hit[k] && !I_Stall)
                  rel_mask[e] = 1'b1;
            end
         end
         if (fwd_hit[k]) begin
            O_Src_Data[k*WIDTH_DATA +: WIDTH_DATA] = I_WB_Data;
            O_Src_Hit[k] = 1'b1;
         end else if (buf_hit[k]) begin
            O_Src_Data[k*WIDTH_DATA +: WIDTH_DATA] = buf_data[k];
            O_Src_Hit[k] = 1'b1;
         end else if (I_Src_Valid[k]) begin
            O_Src_Data[k*WIDTH_DATA +: WIDTH_DATA] = I_Src_Data[k*WIDTH_DATA +: WIDTH_DATA];
         end
      end
   end

   always_comb begin
      wb_present = 1'b0;
      wb_ptr     = '0;
      age_flat   = '0;
      for (int unsigned e = 0; e < BUFF_SIZE; e++) begin
         if (valid_q[e] && (idx_q[e] == I_WB_Idx)) begin
            wb_present = 1'b1;
            wb_ptr     = WIDTH_PTR'(e);
         end
         age_flat[e*WIDTH_NUM +: WIDTH_NUM] = age_q[e];
      end
      valid_kept = valid_q & ~rel_mask;
   end

   bypass_buff_mp_age_sel #(
      .BUFF_SIZE (BUFF_SIZE),
      .WIDTH_NUM (WIDTH_NUM)
   ) u_age_sel (
      .valid      (valid_kept),
      .age        (age_flat),
      .free_ptr   (free_ptr),
      .victim_ptr (victim_ptr),
      .any_free   (any_free)
   );

   always_comb begin
      valid_d = valid_kept;
      idx_d   = idx_q;
      data_d  = data_q;
      age_d   = age_q;
      evict_d = 1'b0;
      tgt_ptr = '0;
      if (I_Flush)
         valid_d = '0;
      if (I_WB_Valid) begin
         // a store re-validates its target, so it wins over a same-cycle release
         if (I_Flush) begin
            tgt_ptr = '0;
         end else if (wb_present) begin
            tgt_ptr = wb_ptr;
         end else begin
            tgt_ptr = any_free ? free_ptr : victim_ptr;
            evict_d = !any_free;
            for (int unsigned e = 0; e < BUFF_SIZE; e++)
               if (valid_d[e] && (WIDTH_PTR'(e) != tgt_ptr) && (age_d[e] != '1))
                  age_d[e] = age_d[e] + WIDTH_NUM'(1);
         end
         valid_d[tgt_ptr] = 1'b1;
         idx_d[tgt_ptr]   = I_WB_Idx;
         data_d[tgt_ptr]  = I_WB_Data;
         age_d[tgt_ptr]   = '0;
      end
      num_d = '0;
      for (int unsigned e = 0; e < BUFF_SIZE; e++)
         num_d = num_d + WIDTH_NUM'(valid_d[e]);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         for (int unsigned e = 0; e < BUFF_SIZE; e++) begin
            idx_q[e]  <= '0;
            data_q[e] <= '0;
            age_q[e]  <= '0;
         end
         O_Num   <= '0;
         O_Full  <= 1'b0;
         O_Empty <= 1'b1;
         O_Evict <= 1'b0;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         age_q   <= age_d;
         O_Num   <= num_d;
         O_Full  <= (num_d == WIDTH_NUM'(BUFF_SIZE));
         O_Empty <= (num_d == '0);
         O_Evict <= evict_d;
      end
   end

endmodule

// File: tb/tb_bypass_buff_mp.sv
// Bench for bypass_buff_mp: directed scenarios plus random traffic against a behavioural model.
module tb_bypass_buff_mp;

   localparam int NS = 3;
   localparam int BS = 8;
   localparam int WI = 8;
   localparam int WD = 32;

   logic           clock = 1'b0;
   logic           reset, stall, flush, wb_valid;
   logic [WI-1:0]  wb_idx;
   logic [WD-1:0]  wb_data;
   logic [NS-1:0]  src_valid, src_last, src_hit_o;
   logic [NS*WI-1:0] src_idx;
   logic [NS*WD-1:0] src_data, src_data_o;
   logic           evict_o, full_o, empty_o;
   logic [3:0]     num_o;

   always #5 clock = ~clock;

   bypass_buff_mp #(
      .BUFF_SIZE  (BS),
      .NUM_SRC    (NS),
      .WIDTH_IDX  (WI),
      .WIDTH_DATA (WD),
      .FWD_WB     (1)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .I_Stall     (stall),
      .I_Flush     (flush),
      .I_WB_Valid  (wb_valid),
      .I_WB_Idx    (wb_idx),
      .I_WB_Data   (wb_data),
      .I_Src_Valid (src_valid),
      .I_Src_Idx   (src_idx),
      .I_Src_Last  (src_last),
      .I_Src_Data  (src_data),
      .O_Src_Data  (src_data_o),
      .O_Src_Hit   (src_hit_o),
      .O_Evict     (evict_o),
      .O_Num       (num_o),
      .O_Full      (full_o),
      .O_Empty     (empty_o)
   );

   // behavioural model: slot contents plus age as plain integers
   bit          m_valid [BS];
   logic [7:0]  m_idx   [BS];
   logic [31:0] m_data  [BS];
   int          m_age   [BS];
   bit          m_evict;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_find(input logic [7:0] idx);
      for (int e = 0; e < BS; e++)
         if (m_valid[e] && m_idx[e] == idx) return e;
      return -1;
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int e = 0; e < BS; e++) n += int'(m_valid[e]);
      return n;
   endfunction

   task automatic model_clear();
      for (int e = 0; e < BS; e++) begin
         m_valid[e] = 0;
         m_age[e]   = 0;
      end
      m_evict = 0;
   endtask

   task automatic model_lookup(input int k, output logic [31:0] d, output logic h,
                               output bit rel, output int ent);
      logic [7:0] sidx;
      sidx = src_idx[k*WI +: WI];
      ent  = -1;
      rel  = 0;
      if (!src_valid[k]) begin
         d = '0; h = 1'b0;
      end else if (wb_valid && wb_idx == sidx) begin
         d = wb_data; h = 1'b1;
      end else begin
         ent = model_find(sidx);
         if (ent >= 0) begin
            d = m_data[ent]; h = 1'b1;
            rel = src_last[k] && !stall;
         end else begin
            d = src_data[k*WD +: WD]; h = 1'b0;
         end
      end
   endtask

   task automatic model_update();
      bit rel_e [BS];
      logic [31:0] d;
      logic h;
      bit r;
      int ent, pres, tgt;
      if (reset) begin
         model_clear();
         return;
      end
      for (int e = 0; e < BS; e++) rel_e[e] = 0;
      for (int k = 0; k < NS; k++) begin
         model_lookup(k, d, h, r, ent);
         if (r) rel_e[ent] = 1;
      end
      pres = model_find(wb_idx);
      for (int e = 0; e < BS; e++) if (rel_e[e] || flush) m_valid[e] = 0;
      m_evict = 0;
      if (wb_valid) begin
         if (flush) tgt = 0;
         else if (pres >= 0) tgt = pres;
         else begin
            tgt = -1;
            for (int e = 0; e < BS; e++) if (!m_valid[e] && tgt < 0) tgt = e;
            if (tgt < 0) begin
               m_evict = 1;
               tgt = 0;
               for (int e = 1; e < BS; e++) if (m_age[e] > m_age[tgt]) tgt = e;
            end
            for (int e = 0; e < BS; e++)
               if (m_valid[e] && e != tgt) m_age[e] = (m_age[e] < 15) ? m_age[e] + 1 : 15;
         end
         m_valid[tgt] = 1;
         m_idx[tgt]   = wb_idx;
         m_data[tgt]  = wb_data;
         m_age[tgt]   = 0;
      end
   endtask

   task automatic step();
      logic [31:0] d;
      logic h;
      bit r;
      int ent, n;
      #1;
      for (int k = 0; k < NS; k++) begin
         model_lookup(k, d, h, r, ent);
         check($sformatf("hit%0d", k), src_hit_o[k], h);
         check($sformatf("data%0d", k), src_data_o[k*WD +: WD], d);
      end
      model_update();
      @(posedge clock);
      #1;
      n = model_count();
      check("num", num_o, n);
      check("full", full_o, n == BS);
      check("empty", empty_o, n == 0);
      check("evict", evict_o, m_evict);
   endtask

   task automatic idle();
      reset = 0; stall = 0; flush = 0; wb_valid = 0;
      wb_idx = '0; wb_data = '0;
      src_valid = '0; src_last = '0; src_idx = '0; src_data = '0;
   endtask

   task automatic set_wb(input logic [7:0] idx, input logic [31:0] d);
      wb_valid = 1; wb_idx = idx; wb_data = d;
   endtask

   task automatic set_src(input int k, input logic [7:0] idx, input bit last, input logic [31:0] rf);
      src_valid[k] = 1;
      src_idx[k*WI +: WI] = idx;
      src_last[k] = last;
      src_data[k*WD +: WD] = rf;
   endtask

   initial begin
      idle();
      model_clear();
      reset = 1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 0;
      check("rst_num", num_o, 0);
      check("rst_empty", empty_o, 1);
      check("rst_full", full_o, 0);
      check("rst_evict", evict_o, 0);

      // store then lookup
      idle(); set_wb(5, 32'hAAAA); step();
      idle(); set_src(0, 5, 0, 32'h1111); #1;
      check("s1_data", src_data_o[31:0], 32'hAAAA);
      check("s1_hit", src_hit_o[0], 1);
      check("s1_num", num_o, 1);
      step();

      // same-cycle forwarding
      idle(); flush = 1; step();
      idle(); set_wb(3, 32'h1234); set_src(1, 3, 0, 32'h9999); #1;
      check("s2_fwd_data", src_data_o[63:32], 32'h1234);
      check("s2_fwd_hit", src_hit_o[1], 1);
      step();

      // fill then evict the oldest
      idle(); flush = 1; step();
      for (int i = 0; i < 8; i++) begin
         idle(); set_wb(8'(i), 32'h100 + i); step();
      end
      check("s3_full", full_o, 1);
      idle(); set_wb(9, 32'h900); step();
      check("s3_evict", evict_o, 1);
      check("s3_num", num_o, 8);
      idle(); set_src(0, 0, 0, 32'h5555); #1;
      check("s3_miss_data", src_data_o[31:0], 32'h5555);
      check("s3_miss_hit", src_hit_o[0], 0);
      step();
      check("s3_evict_once", evict_o, 0);

      // in-place update
      idle(); flush = 1; step();
      idle(); set_wb(4, 1); step();
      idle(); set_wb(4, 2); step();
      check("s4_num", num_o, 1);
      idle(); set_src(0, 4, 0, 32'h77); #1;
      check("s4_data", src_data_o[31:0], 2);
      step();

      // release held off by stall, then taken
      idle(); set_src(0, 4, 1, 0); stall = 1; step();
      check("s5_stall_num", num_o, 1);
      idle(); set_src(0, 4, 1, 0); step();
      check("s5_rel_num", num_o, 0);
      check("s5_rel_empty", empty_o, 1);

      // flush with store
      idle(); flush = 1; set_wb(7, 32'h7777); step();
      check("s6_num", num_o, 1);
      idle(); set_src(2, 7, 0, 0); #1;
      check("s6_hit", src_hit_o[2], 1);
      step();

      // reset mid-fill
      for (int i = 0; i < 4; i++) begin
         idle(); set_wb(8'(20 + i), 32'(i)); step();
      end
      idle(); reset = 1; step();
      check("s7_empty", empty_o, 1);
      idle();
      for (int k = 0; k < NS; k++) set_src(k, 8'(20 + k), 0, 32'hF0 + k);
      #1;
      for (int k = 0; k < NS; k++) check($sformatf("s7_miss%0d", k), src_hit_o[k], 0);
      step();

      // random traffic
      repeat (600) begin
         idle();
         reset    = ($urandom_range(0, 99) == 0);
         flush    = ($urandom_range(0, 29) == 0);
         stall    = ($urandom_range(0, 3) == 0);
         wb_valid = ($urandom_range(0, 2) != 0);
         wb_idx   = 8'($urandom_range(0, 11));
         wb_data  = $urandom;
         for (int k = 0; k < NS; k++) begin
            src_valid[k] = ($urandom_range(0, 3) != 0);
            src_idx[k*WI +: WI] = 8'($urandom_range(0, 11));
            src_last[k] = ($urandom_range(0, 2) == 0);
            src_data[k*WD +: WD] = $urandom;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
